smem_fill_ctrl: RTL and testbench
=================================

# smem_fill_ctrl

Hardware fill/clear sequencer for the screen memory write port, sitting between the memory map and `screenmem` port 1. On a start command it writes one character code into a contiguous, wrap-around range of screen cells, one cell per cycle, so software does not loop over 1200 stores. CPU stores always win the shared write port; the engine stalls for that cycle and resumes.

## Interface
- `Nloc`, 1200, screen memory depth in cells
- `Dbits`, 2, character code width (`$clog2(Nchars)`)
- `wordsize`, 32, CPU data/address width
- `AW`, `$clog2(Nloc)` (derived localparam, 11), cell index width
- `clk` in 1, system clock, all state on rising edge
- `reset_n` in 1, asynchronous, active-low reset
- `cpu_smem_wr` in 1, CPU store to screen memory this cycle (from `mem_map`)
- `cpu_addr` in `wordsize`, CPU byte address; cell index = `cpu_addr[AW+1:2]`
- `cpu_writedata` in `wordsize`, CPU store data; code = `cpu_writedata[Dbits-1:0]`
- `start` in 1, one-cycle command strobe
- `abort` in 1, one-cycle cancel strobe
- `fill_char` in `Dbits`, code to write, sampled on `start`
- `start_idx` in `AW`, first cell, sampled on `start`
- `count` in `AW+1`, number of cells, sampled on `start`
- `smem_wr` out 1, write enable to `screenmem`
- `smem_addr` out `AW`, write/read index to `screenmem` port 1
- `smem_din` out `Dbits`, write data to `screenmem`
- `busy` out 1, engine not idle
- `done` out 1, one-cycle completion pulse
- `status` out `wordsize`, `{zeros, err, busy, remaining[AW:0]}`, read through memory map

## Operation
- States: IDLE, FILL, DONE.
- IDLE + `start`:
  - `start_idx >= Nloc`: set `err`, go to DONE, no writes.
  - `count == 0`: clear `err`, go to DONE, no writes.
  - Otherwise: clear `err`; latch `ptr = start_idx`, `remaining = min(count, Nloc)`, `char = fill_char`; go to FILL.
- FILL, `cpu_smem_wr = 0`: write `char` at `ptr`. `ptr` increments, wrapping `Nloc-1 -> 0`. `remaining` decrements. If `remaining` was 1, go to DONE.
- FILL, `cpu_smem_wr = 1`: CPU write passes through. Engine holds `ptr`/`remaining`; no engine write that cycle.
- DONE: `done = 1` for exactly one cycle, then IDLE.
- `start` outside IDLE: ignored.
- `abort` in FILL: go to IDLE next edge, no `done`, `remaining` keeps its residual value. `abort` in IDLE/DONE: ignored.
- `abort` and `start` together in IDLE: `start` wins.
- Output mux (combinational):
  - `smem_wr = cpu_smem_wr | (state==FILL)`
  - `smem_addr = (cpu_smem_wr | state!=FILL) ? cpu_addr[AW+1:2] : ptr`, so CPU reads of `screenmem` are unaffected.
  - `smem_din` follows the same select, between `cpu_writedata[Dbits-1:0]` and `char`.
- `busy = (state != IDLE)`.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, `ptr=0`, `remaining=0`, `char=0`, `err=0`. Outputs: `busy=0`, `done=0`, `smem_wr=cpu_smem_wr`, `status=0`.
- `start` sampled at edge k:
  - First engine write occupies cycle k+1.
  - With no CPU contention, N writes occupy cycles k+1..k+N.
  - `done` is high in cycle k+N+1; `busy` is high in cycles k+1..k+N+1.
  - Each CPU store during FILL adds exactly one cycle.
- Zero-count and error starts: `done` is high in cycle k+1, `busy` for that one cycle.
- Reset during FILL: immediate return to IDLE; the remaining cells are not written.

## Structure
- Package `smem_fill_pkg`: `typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t`, and the status bit positions (`ERR_BIT = AW+2`, `BUSY_BIT = AW+1`).
- Sub-module `wrap_counter`: a parameterised modulo-`Nloc` index register with `load`/`inc` controls, used for `ptr`.
- Everything else is flat in `smem_fill_ctrl`.

## Test plan
- Full clear: `start_idx=0`, `count=1200`, `fill_char=0`, no CPU traffic -> 1200 writes at indices 0..1199, `done` exactly 1201 cycles after the `start` edge, `status` remaining = 0.
- Wrap: `start_idx=1198`, `count=4`, `fill_char=3` -> writes at 1198, 1199, 0, 1 with data 3; cells 2 and 1197 untouched.
- Contention: `start_idx=10`, `count=5`; CPU store index 500, data 2 in the 3rd FILL cycle -> bus shows 500/2 that cycle, engine writes 10..14 in order, `done` one cycle later than uncontended.
- Degenerate commands:
  - `count=0` -> `done` next cycle, zero writes, `err=0`.
  - `start_idx=1300` -> `done` next cycle, zero writes, `status[ERR_BIT]=1`.
  - `count=2000` -> exactly 1200 writes.
- Abort/reset: `abort` after 7 writes of a 20-cell fill -> IDLE, no `done`, `status` remaining = 13. Repeat with `reset_n` low mid-fill -> all outputs at reset values immediately, no further engine writes.

Source files
------------

// File: rtl/smem_fill_pkg.sv
// Shared types and constants for the screen memory fill sequencer.
// Status word layout: {zeros, err, busy, remaining[AW:0]}.
package smem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  localparam int NLOC     = 1200;
  localparam int AW       = $clog2(NLOC);
  localparam int ERR_BIT  = AW + 2;
  localparam int BUSY_BIT = AW + 1;

  function automatic int err_bit(input int aw);
    return aw + 2;
  endfunction

  function automatic int busy_bit(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/smem_fill_if.sv
// Screen memory port-1 write bus (enable, cell index, code).
// master: drives the bus; slave: screenmem side.
interface smem_fill_if #(
  parameter int AW    = 11,
  parameter int DBITS = 2
);

  logic             smem_wr;
  logic [AW-1:0]    smem_addr;
  logic [DBITS-1:0] smem_din;

  modport master (
    output smem_wr,
    output smem_addr,
    output smem_din
  );

  modport slave (
    input smem_wr,
    input smem_addr,
    input smem_din
  );

endinterface

// File: rtl/smem_fill_ctrl_wrap_counter.sv
// Modulo-N index register with load and increment controls.
// Ports: clk, rst_n, load, inc, d (load value), q (index).
module wrap_counter #(
  parameter int N = 1200,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= (q == LAST) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/smem_fill.sv
// Screen memory fill/clear sequencer sharing port 1 with CPU stores.
// Ports: clk, reset_n, CPU store side, start/abort command, mem bus, busy/done/status.
module smem_fill_ctrl
  import smem_fill_pkg::*;
#(
  parameter  int Nloc     = 1200,
  parameter  int Dbits    = 2,
  parameter  int wordsize = 32,
  localparam int AW       = $clog2(Nloc)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_smem_wr,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_writedata,
  input  logic                start,
  input  logic                abort,
  input  logic [Dbits-1:0]    fill_char,
  input  logic [AW-1:0]       start_idx,
  input  logic [AW:0]         count,
  smem_fill_if.master         mem,
  output logic                busy,
  output logic                done,
  output logic [wordsize-1:0] status
);

  localparam logic [AW:0] NLOC_C = (AW+1)'(Nloc);
  localparam int          EB     = err_bit(AW);
  localparam int          BB     = busy_bit(AW);

  fill_state_t      state;
  fill_state_t      state_nx;
  logic [AW-1:0]    ptr;
  logic [AW:0]      remaining;
  logic [Dbits-1:0] chr;
  logic             err;

  logic filling;
  logic idx_ok;
  logic cnt_nz;
  logic take;
  logic load;
  logic step;
  logic cpu_sel;

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[wordsize-1:AW+2],
                         cpu_addr[1:0],
                         cpu_writedata[wordsize-1:Dbits]};

  assign idx_ok = {1'b0, start_idx} < NLOC_C;
  assign cnt_nz = |count;
  assign take   = (state == IDLE) & start;
  assign load   = take & idx_ok & cnt_nz;
  // Abort cycles hold the counters so the residual stays visible.
  assign step   = filling & ~cpu_smem_wr & ~abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = load ? FILL : DONE;
        end
      end
      FILL: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (!cpu_smem_wr && remaining == 1) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    filling = 1'b0;
    unique case (state)
      IDLE: begin
      end
      FILL: begin
        busy    = 1'b1;
        filling = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  wrap_counter #(
    .N (Nloc),
    .W (AW)
  ) u_ptr (
    .clk   (clk),
    .rst_n (reset_n),
    .load  (load),
    .inc   (step),
    .d     (start_idx),
    .q     (ptr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      chr       <= '0;
      err       <= 1'b0;
    end else if (take) begin
      err <= ~idx_ok;
      if (load) begin
        remaining <= (count > NLOC_C) ? NLOC_C : count;
        chr       <= fill_char;
      end
    end else if (step) begin
      remaining <= remaining - 1'b1;
    end
  end

  // CPU keeps the port whenever it stores or the engine is not filling,
  // so CPU reads through port 1 see their own address.
  assign cpu_sel = cpu_smem_wr | ~filling;

  always_comb begin
    mem.smem_wr   = cpu_smem_wr | filling;
    mem.smem_addr = cpu_sel ? cpu_addr[AW+1:2] : ptr;
    mem.smem_din  = cpu_sel ? cpu_writedata[Dbits-1:0] : chr;
  end

  always_comb begin
    status         = '0;
    status[AW:0]   = remaining;
    status[BB]     = busy;
    status[EB]     = err;
  end

endmodule

// File: tb/tb_smem_fill_ctrl.sv
// Self-checking bench for smem_fill_ctrl.
// Scoreboard of expected bus writes checked on every falling edge.
module tb_smem_fill_ctrl;
  import smem_fill_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_smem_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_writedata;
  logic        start;
  logic        abort;
  logic [1:0]  fill_char;
  logic [10:0] start_idx;
  logic [11:0] count;
  logic        busy;
  logic        done;
  logic [31:0] status;

  smem_fill_if #(.AW(11), .DBITS(2)) mem ();

  smem_fill_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_smem_wr   (cpu_smem_wr),
    .cpu_addr      (cpu_addr),
    .cpu_writedata (cpu_writedata),
    .start         (start),
    .abort         (abort),
    .fill_char     (fill_char),
    .start_idx     (start_idx),
    .count         (count),
    .mem           (mem.master),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [1:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp    = 0;
  int  n_fail   = 0;
  int  n_writes = 0;
  bit  mon_en   = 1'b0;

  always @(negedge clk) begin
    if (mon_en && mem.smem_wr === 1'b1) begin
      wr_t e;
      n_writes++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                 mem.smem_addr, mem.smem_din);
      end else begin
        e = exp_q.pop_front();
        if (mem.smem_addr !== e.a || mem.smem_din !== e.d) begin
          n_fail++;
          $display("FAIL bus_write: got addr %0d data %0d, required addr %0d data %0d",
                   mem.smem_addr, mem.smem_din, e.a, e.d);
        end
      end
    end
  end

  task automatic push_fill(input int idx, input int n, input logic [1:0] ch);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.a = 11'((idx + i) % NLOC);
      e.d = ch;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int idx, input int cnt, input logic [1:0] ch);
    @(posedge clk);
    #1;
    start_idx = 11'(idx);
    count     = 12'(cnt);
    fill_char = ch;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    fill_char = 2'd0;
  endtask

  task automatic wait_done(input int bound, output int cyc, output bit seen,
                           output logic busy_at);
    cyc     = 0;
    seen    = 1'b0;
    busy_at = 1'b0;
    while (!seen && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        seen    = 1'b1;
        busy_at = busy;
      end
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    cpu_smem_wr   = 1'b1;
    cpu_addr      = 32'(77 * 4);
    cpu_writedata = 32'd1;
    start         = 1'b0;
    abort         = 1'b0;
    fill_char     = 2'd0;
    start_idx     = '0;
    count         = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy %b done %b status %h, required 0 0 0",
               busy, done, status);
    end
    n_cmp++;
    if (mem.smem_wr !== 1'b1 || mem.smem_addr !== 11'd77 || mem.smem_din !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_passthru: got wr %b addr %0d din %0d, required 1 77 1",
               mem.smem_wr, mem.smem_addr, mem.smem_din);
    end
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    cpu_smem_wr = 1'b0;
    cpu_addr    = '0;
    cpu_writedata = '0;
    mon_en      = 1'b1;
  endtask

  task automatic test_full_clear();
    int cyc;
    bit seen;
    logic b;
    int w0;
    w0 = n_writes;
    push_fill(0, 1200, 2'd0);
    pulse_start(0, 1200, 2'd0);
    wait_done(1300, cyc, seen, b);
    n_cmp++;
    if (!seen || cyc != 1201 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL full_done: got seen %0d cyc %0d busy %b, required 1 1201 1",
               seen, cyc, b);
    end
    n_cmp++;
    if (n_writes - w0 != 1200 || status[11:0] !== 12'd0) begin
      n_fail++;
      $display("FAIL full_count: got writes %0d rem %0d, required 1200 0",
               n_writes - w0, status[11:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done %b busy %b, required 0 0", done, busy);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit seen;
    logic b;
    push_fill(1198, 4, 2'd3);
    pulse_start(1198, 4, 2'd3);
    wait_done(20, cyc, seen, b);
    n_cmp++;
    if (!seen || cyc != 5) begin
      n_fail++;
      $display("FAIL wrap_done: got seen %0d cyc %0d, required 1 5", seen, cyc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_left: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    int cyc;
    bit seen;
    logic b;
    wr_t e;
    push_fill(10, 2, 2'd1);
    e.a = 11'd500;
    e.d = 2'd2;
    exp_q.push_back(e);
    push_fill(12, 3, 2'd1);
    pulse_start(10, 5, 2'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    cpu_smem_wr   = 1'b1;
    cpu_addr      = 32'(500 * 4);
    cpu_writedata = 32'd2;
    @(posedge clk);
    #1;
    cpu_smem_wr   = 1'b0;
    cpu_addr      = '0;
    cpu_writedata = '0;
    wait_done(20, cyc, seen, b);
    n_cmp++;
    if (!seen || cyc + 3 != 7) begin
      n_fail++;
      $display("FAIL cont_done: got seen %0d cyc %0d, required 1 7", seen, cyc + 3);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL cont_left: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_degenerate();
    int cyc;
    bit seen;
    logic b;
    int w0;
    w0 = n_writes;
    pulse_start(1300, 5, 2'd2);
    wait_done(10, cyc, seen, b);
    n_cmp++;
    if (!seen || cyc != 1 || b !== 1'b1 || n_writes != w0) begin
      n_fail++;
      $display("FAIL err_done: got seen %0d cyc %0d busy %b writes %0d, required 1 1 1 0",
               seen, cyc, b, n_writes - w0);
    end
    n_cmp++;
    if (status[ERR_BIT] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_bit: got %b, required 1", status[ERR_BIT]);
    end
    pulse_start(100, 0, 2'd2);
    wait_done(10, cyc, seen, b);
    n_cmp++;
    if (!seen || cyc != 1 || n_writes != w0 || status[ERR_BIT] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_cnt: got seen %0d cyc %0d writes %0d err %b, required 1 1 0 0",
               seen, cyc, n_writes - w0, status[ERR_BIT]);
    end
    push_fill(5, 1200, 2'd1);
    pulse_start(5, 2000, 2'd1);
    wait_done(1300, cyc, seen, b);
    n_cmp++;
    if (!seen || cyc != 1201 || n_writes - w0 != 1200) begin
      n_fail++;
      $display("FAIL over_cnt: got seen %0d cyc %0d writes %0d, required 1 1201 1200",
               seen, cyc, n_writes - w0);
    end
  endtask

  task automatic test_abort();
    bit any_done;
    push_fill(0, 8, 2'd1);
    pulse_start(0, 20, 2'd1);
    repeat (7) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    any_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) any_done = 1'b1;
    end
    n_cmp++;
    if (busy !== 1'b0 || any_done) begin
      n_fail++;
      $display("FAIL abort_idle: got busy %b done_seen %0d, required 0 0", busy, any_done);
    end
    n_cmp++;
    if (status[11:0] !== 12'd13 || status[BUSY_BIT] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rem: got rem %0d busy %b, required 13 0",
               status[11:0], status[BUSY_BIT]);
    end
  endtask

  task automatic test_reset_mid();
    push_fill(0, 4, 2'd2);
    pulse_start(0, 20, 2'd2);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== 32'd0 || mem.smem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy %b done %b status %h wr %b, required 0 0 0 0",
               busy, done, status, mem.smem_wr);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_after: got busy %b pending %0d, required 0 0",
               busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_clear();
    test_wrap();
    test_contention();
    test_degenerate();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
